ar_cart_mem_arbiter: RTL and testbench

//  Shares the single 512KB cartridge RAM bank ($400000-$47FFFF) between the CPU-side cartridge decode and the host/bootloader upload port.

---
 rtl/ar_cart_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_ar_cart_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ar_cart_mem_arbiter.sv
// Arbiter for the 512KB cartridge RAM bank. It is shared by the CPU cartridge decode and the host upload port.
// It runs one memory transaction at a time, write-protects the ROM half after boot and times out stalled accesses.
module ar_cart_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        boot,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_be,
    input  logic [17:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [17:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic        host_err,
    output logic [15:0] host_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [17:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);
    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]      TMO_LAST   = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, CPU, HOST, DONE} state_t;

    state_t        state, state_d;
    logic [SW-1:0] starve, starve_d;
    logic [7:0]    tmo, tmo_d;
    logic          mem_req_d, mem_we_d;
    logic [1:0]    mem_be_d;
    logic [17:0]   mem_addr_d;
    logic [15:0]   mem_wdata_d;
    logic          cpu_ack_d, host_ack_d, host_err_d;
    logic [15:0]   cpu_rdata_d, host_rdata_d;
    logic          host_first, cpu_rom_wr, host_rom_wr;

    assign host_first  = host_req && (starve == STARVE_MAX);
    assign cpu_rom_wr  = cpu_we && !cpu_addr[17];
    assign host_rom_wr = host_we && !host_addr[17] && !boot;

    always_comb begin
        // NOTE: every signal gets its default first so no branch can leave one unassigned and infer a latch.
        state_d      = state;
        starve_d     = host_req ? starve : '0;
        tmo_d        = tmo;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_be_d     = mem_be;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        cpu_ack_d    = 1'b0;
        host_ack_d   = 1'b0;
        host_err_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata;
        host_rdata_d = host_rdata;

        unique case (state)
            IDLE: begin
                tmo_d = '0;
                if (cpu_req && !host_first) begin
                    if (host_req) starve_d = starve + SW'(1);
                    if (cpu_rom_wr) begin
                        // Protected write: acknowledged without touching memory.
                        cpu_ack_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = cpu_we;
                        mem_be_d    = cpu_be;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        state_d     = CPU;
                    end
                end else if (host_req) begin
                    starve_d = '0;
                    if (host_rom_wr) begin
                        host_ack_d = 1'b1;
                        host_err_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = host_we;
                        mem_be_d    = 2'b11;
                        mem_addr_d  = host_addr;
                        mem_wdata_d = host_wdata;
                        state_d     = HOST;
                    end
                end
            end
            CPU, HOST: begin
                // A mem_ack coinciding with the last timeout cycle is a normal completion.
                if (mem_ack || tmo == TMO_LAST) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (state == CPU) begin
                        cpu_ack_d   = 1'b1;
                        cpu_rdata_d = mem_ack ? mem_rdata : 16'hFFFF;
                    end else begin
                        host_ack_d   = 1'b1;
                        host_err_d   = !mem_ack;
                        host_rdata_d = mem_ack ? mem_rdata : 16'hFFFF;
                    end
                end else begin
                    tmo_d = tmo + 8'd1;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop updates from pre-edge values.
        if (!reset) begin
            state      <= IDLE;
            starve     <= '0;
            tmo        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            state      <= state_d;
            starve     <= starve_d;
            tmo        <= tmo_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_be     <= mem_be_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            cpu_ack    <= cpu_ack_d;
            host_ack   <= host_ack_d;
            host_err   <= host_err_d;
            cpu_rdata  <= cpu_rdata_d;
            host_rdata <= host_rdata_d;
        end
    end
endmodule

// File: tb/tb_ar_cart_mem_arbiter.sv
// Scoreboard bench for ar_cart_mem_arbiter. A word-array reference model predicts each response at issue time.
// A bench-side memory responder and an ack monitor then check what the arbiter actually delivers.
module tb_ar_cart_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset, boot;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [1:0]  cpu_be;
    logic [17:0] cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        host_req, host_we, host_ack, host_err;
    logic [17:0] host_addr;
    logic [15:0] host_wdata, host_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [1:0]  mem_be;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        bit          chk;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        host_q[$];
    logic [15:0] sdram   [int];
    logic [15:0] ref_mem [int];
    bit          order_q[$];
    bit          rec_order    = 1'b0;
    int          n_checks     = 0;
    int          n_fail       = 0;
    int          lat_cfg      = 0;    // 0 random 1..4, >0 fixed, <0 never acks
    bit          late_ack     = 1'b0; // keep counting to mem_ack even if mem_req drops
    int          n_mem_acc    = 0;
    int          last_req_len = 0;

    always #5 clk = ~clk;

    ar_cart_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYC(255)) dut (
        .clk(clk), .reset(reset), .boot(boot),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: ack missing or unexpected", name);
    endtask

    function automatic logic [15:0] init_val(input int a);
        return 16'(a) ^ 16'hA5A5;
    endfunction

    function automatic logic [15:0] sdram_rd(input int a);
        return sdram.exists(a) ? sdram[a] : init_val(a);
    endfunction

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic void ref_wr(input int a, input logic [1:0] be, input logic [15:0] wd);
        logic [15:0] v = ref_rd(a);
        if (be[1]) v[15:8] = wd[15:8];
        if (be[0]) v[7:0]  = wd[7:0];
        ref_mem[a] = v;
    endfunction

    // Stand-in SDRAM: acknowledges each mem_req after a configurable latency.
    initial begin : responder
        bit          pending = 1'b0;
        int          cnt = 0;
        int          lat = 0;
        logic [17:0] a;
        logic        we_l;
        logic [1:0]  be_l;
        logic [15:0] wd_l, v;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!pending && mem_req) begin
                pending = 1'b1;
                cnt     = 0;
                a       = mem_addr;
                we_l    = mem_we;
                be_l    = mem_be;
                wd_l    = mem_wdata;
                n_mem_acc++;
                lat = (lat_cfg == 0) ? int'($urandom_range(4, 1)) : lat_cfg;
                if (we_l && !a[17]) check("rom_write_gate", 32'(a < 18'h100 && boot), 32'd1);
                if (a >= 18'h30000 || a < 18'h100) check("host_be", 32'(be_l), 32'd3);
            end
            if (pending) begin
                if (!mem_req && !late_ack) begin
                    pending      = 1'b0;
                    last_req_len = cnt;
                end else begin
                    cnt++;
                    if (lat > 0 && cnt == lat) begin
                        mem_ack   = 1'b1;
                        mem_rdata = sdram_rd(int'(a));
                        if (we_l) begin
                            v = sdram_rd(int'(a));
                            if (be_l[1]) v[15:8] = wd_l[15:8];
                            if (be_l[0]) v[7:0]  = wd_l[7:0];
                            sdram[int'(a)] = v;
                        end
                        pending = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ack) begin
                if (rec_order) order_q.push_back(1'b0);
                if (cpu_q.size() == 0) fail("cpu_ack_unexpected");
                else begin
                    e = cpu_q.pop_front();
                    if (e.chk) check("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
                end
            end
            if (host_ack) begin
                if (rec_order) order_q.push_back(1'b1);
                if (host_q.size() == 0) fail("host_ack_unexpected");
                else begin
                    e = host_q.pop_front();
                    check("host_err", 32'(host_err), 32'(e.err));
                    if (e.chk) check("host_rdata", 32'(host_rdata), 32'(e.rdata));
                end
            end
        end
    end

    task automatic cpu_do(input logic we, input logic [1:0] be, input logic [17:0] addr,
                          input logic [15:0] wd, input bit tmo);
        exp_t e;
        int   n = 0;
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
        e = '{16'h0000, 1'b0, 1'b0};
        if (tmo) e = '{16'hFFFF, 1'b0, 1'b1};
        else if (!we) e = '{ref_rd(int'(addr)), 1'b0, 1'b1};
        else if (addr[17]) ref_wr(int'(addr), be, wd);
        cpu_q.push_back(e);
        do begin @(negedge clk); n++; end while (!cpu_ack && n < 1000);
        if (!cpu_ack) begin
            fail("cpu_ack_wait");
            @(posedge clk);
            #1 cpu_req = 1'b0;
        end
    endtask

    task automatic host_do(input logic we, input logic [17:0] addr, input logic [15:0] wd, input bit tmo);
        exp_t e;
        int   n = 0;
        @(posedge clk);
        #1;
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
        e = '{16'h0000, 1'b0, 1'b0};
        if (tmo) e = '{16'hFFFF, 1'b1, 1'b1};
        else if (we && !addr[17] && !boot) e.err = 1'b1;
        else if (we) ref_wr(int'(addr), 2'b11, wd);
        else e = '{ref_rd(int'(addr)), 1'b0, 1'b1};
        host_q.push_back(e);
        do begin @(negedge clk); n++; end while (!host_ack && n < 1000);
        if (!host_ack) begin
            fail("host_ack_wait");
            @(posedge clk);
            #1 host_req = 1'b0;
        end
    endtask

    task automatic cpu_idle();
        @(posedge clk);
        #1 cpu_req = 1'b0;
    endtask

    task automatic host_idle();
        @(posedge clk);
        #1 host_req = 1'b0;
    endtask

    task automatic cpu_rand();
        int          k  = int'($urandom_range(3, 0));
        logic [1:0]  be = 2'($urandom);
        logic [15:0] wd = 16'($urandom);
        logic [17:0] ra = 18'h20000 + 18'($urandom_range(31, 0));
        logic [17:0] ro = 18'h00100 + 18'($urandom_range(15, 0));
        case (k)
            0:       cpu_do(1'b0, be, ra, wd, 1'b0);
            1:       cpu_do(1'b1, be, ra, wd, 1'b0);
            2:       cpu_do(1'b0, be, ro, wd, 1'b0);
            default: cpu_do(1'b1, be, ro, wd, 1'b0);
        endcase
    endtask

    task automatic host_rand();
        int          k  = int'($urandom_range(3, 0));
        logic [15:0] wd = 16'($urandom);
        logic [17:0] ro = 18'($urandom_range(63, 0));
        logic [17:0] ra = 18'h30000 + 18'($urandom_range(31, 0));
        case (k)
            0:       host_do(1'b1, ro, wd, 1'b0);
            1:       host_do(1'b0, ro, wd, 1'b0);
            2:       host_do(1'b1, ra, wd, 1'b0);
            default: host_do(1'b0, ra, wd, 1'b0);
        endcase
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int acc0, acks, highs, n;
        bit saw_late;
        reset = 1'b0; boot = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        sdram[32'h20000]   = 16'h1234;
        ref_mem[32'h20000] = 16'h1234;

        // Reset held with a pending CPU read, then first access with 3-cycle memory latency.
        lat_cfg = 3;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 18'h20000;
        cpu_q.push_back('{16'h1234, 1'b0, 1'b1});
        repeat (3) begin
            @(negedge clk);
            check("rst_mem_req", 32'(mem_req), 32'd0);
            check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
            check("rst_host_ack", 32'(host_ack), 32'd0);
            check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk); check("mem_req_before_grant", 32'(mem_req), 32'd0);
        @(negedge clk); check("mem_req_first", 32'(mem_req), 32'd1);
        @(negedge clk); check("cpu_ack_early1", 32'(cpu_ack), 32'd0);
        @(negedge clk); check("cpu_ack_early2", 32'(cpu_ack), 32'd0);
        @(negedge clk); check("cpu_ack_latency", 32'(cpu_ack), 32'd1);
        cpu_idle();

        // Write protection.
        lat_cfg = 0;
        acc0 = n_mem_acc;
        host_do(1'b1, 18'h00010, 16'hBEEF, 1'b0); host_idle();
        cpu_do(1'b1, 2'b11, 18'h00120, 16'h5555, 1'b0); cpu_idle();
        repeat (3) @(negedge clk);
        check("prot_no_mem_req", 32'(n_mem_acc), 32'(acc0));
        boot = 1'b1;
        host_do(1'b1, 18'h00010, 16'hBEEF, 1'b0); host_idle();
        repeat (3) @(negedge clk);
        check("boot_mem_req", 32'(n_mem_acc), 32'(acc0 + 1));
        check("boot_mem_written", 32'(sdram_rd(32'h10)), 32'h0000BEEF);
        host_do(1'b0, 18'h00010, 16'h0000, 1'b0); host_idle();
        boot = 1'b0;

        // Timeouts, then mem_ack landing on the final timeout cycle.
        lat_cfg = -1;
        last_req_len = 0;
        cpu_do(1'b0, 2'b11, 18'h20005, 16'h0000, 1'b1); cpu_idle();
        check("cpu_tmo_len", 32'(last_req_len), 32'd255);
        last_req_len = 0;
        host_do(1'b0, 18'h30003, 16'h0000, 1'b1); host_idle();
        check("host_tmo_len", 32'(last_req_len), 32'd255);
        lat_cfg = 255;
        cpu_do(1'b0, 2'b11, 18'h20005, 16'h0000, 1'b0); cpu_idle();

        // Reset in the middle of an access, with the memory acking late.
        lat_cfg = 6; late_ack = 1'b1;
        @(posedge clk);
        #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h20002;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req && n < 20);
        check("mid_mem_req_up", 32'(mem_req), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0; cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk); check("mem_req_after_reset", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        acks = 0; highs = 0; saw_late = 1'b0;
        repeat (12) begin
            @(negedge clk);
            acks  += int'(cpu_ack) + int'(host_ack);
            highs += int'(mem_req);
            saw_late |= mem_ack;
        end
        check("no_ack_after_reset", 32'(acks), 32'd0);
        check("idle_after_reset", 32'(highs), 32'd0);
        check("late_ack_driven", 32'(saw_late), 32'd1);
        late_ack = 1'b0; lat_cfg = 0;
        cpu_do(1'b0, 2'b11, 18'h20002, 16'h0000, 1'b0); cpu_idle();

        // Continuous contention: CPU x4, HOST, CPU x4, HOST.
        order_q.delete();
        rec_order = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) cpu_rand();
                cpu_idle();
            end
            begin
                for (int i = 0; i < 2; i++) host_rand();
                host_idle();
            end
        join
        rec_order = 1'b0;
        check("grant_count", 32'(order_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < order_q.size(); i++)
            check($sformatf("grant_%0d", i), 32'(order_q[i]), 32'((i == 4 || i == 9) ? 1 : 0));

        // Randomized concurrent traffic, boot low then high.
        for (int b = 0; b < 2; b++) begin
            boot = b[0];
            fork
                begin
                    for (int i = 0; i < 25; i++) cpu_rand();
                    cpu_idle();
                end
                begin
                    for (int i = 0; i < 15; i++) host_rand();
                    host_idle();
                end
            join
        end

        repeat (5) @(negedge clk);
        check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        check("host_q_empty", 32'(host_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
